// File: rtl/mf8_io_uart_pkg.sv
// Shared definitions for the mf8 I/O-bus UART: register offsets, STAT layout, FSM encodings.
package mf8_io_uart_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_DIVL = 2'd2;
    localparam logic [1:0] REG_DIVH = 2'd3;

    localparam int STAT_TX_BUSY  = 0;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_RX_VALID = 2;
    localparam int STAT_OVR      = 3;
    localparam int STAT_FERR     = 4;
    localparam int STAT_TXIE     = 7;

    localparam logic [2:0] LAST_DATA_BIT = 3'd7;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic       txie;
        logic [1:0] rsvd;
        logic       ferr;
        logic       ovr;
        logic       rx_valid;
        logic       tx_full;
        logic       tx_busy;
    } stat_t;

    function automatic logic [7:0] stat_pack(input logic txie, input logic ferr,
                                             input logic ovr, input logic rx_valid,
                                             input logic tx_full, input logic tx_busy);
        stat_t s;
        s.txie     = txie;
        s.rsvd     = 2'b00;
        s.ferr     = ferr;
        s.ovr      = ovr;
        s.rx_valid = rx_valid;
        s.tx_full  = tx_full;
        s.tx_busy  = tx_busy;
        return s;
    endfunction

endpackage

// File: rtl/mf8_io_uart_if.sv
// mf8 core I/O bus: one-cycle read/write strobes, 6-bit address, combinational read data.
interface mf8_io_uart_if;
    logic       IO_Rd;
    logic       IO_Wr;
    logic [5:0] IO_Addr;
    logic [7:0] IO_WData;
    logic [7:0] IO_RData;

    modport master (output IO_Rd, output IO_Wr, output IO_Addr, output IO_WData,
                    input  IO_RData);
    modport slave  (input  IO_Rd, input  IO_Wr, input  IO_Addr, input  IO_WData,
                    output IO_RData);
endinterface

// File: rtl/mf8_uart_rx.sv
// 8N1 receiver: 2-flop sync, start validation at half bit, centre sampling; byte/strobe/ferr.
// Strobe is combinational in the stop-sample cycle; no backpressure, the parent decides overrun.
module mf8_uart_rx
    import mf8_io_uart_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        RXD,
    input  logic [15:0] div,
    output logic [7:0]  rx_byte,
    output logic        rx_stb,
    output logic        rx_ferr
);

    logic rxd_s1, rxd_s2, rxd_s3;
    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [15:0] div_half, half_m1;
    logic        fall, sample;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_s3 <= 1'b1;
        end else begin
            rxd_s1 <= RXD;
            rxd_s2 <= rxd_s1;
            rxd_s3 <= rxd_s2;
        end
    end

    // Countdown to the start re-check: (DIV+1)/2 clocks after the edge, at least one.
    assign div_half = {1'b0, div[15:1]};
    assign half_m1  = (div[0] || div_half == 16'd0) ? div_half : div_half - 16'd1;
    assign fall     = rxd_s3 & ~rxd_s2;
    assign sample   = (rx_cnt_q == 16'd0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q - 16'd1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = 16'd0;
                if (fall) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = half_m1;
                end
            end
            RX_START: begin
                if (sample) begin
                    rx_cnt_d = div;
                    rx_bit_d = 3'd0;
                    rx_state_d = rxd_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (sample) begin
                    rx_cnt_d   = div;
                    rx_shift_d = {rxd_s2, rx_shift_q[7:1]};
                    if (rx_bit_q == LAST_DATA_BIT) rx_state_d = RX_STOP;
                    else                           rx_bit_d   = rx_bit_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (sample) begin
                    rx_cnt_d   = 16'd0;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign rx_stb  = (rx_state_q == RX_STOP) && sample;
    assign rx_ferr = ~rxd_s2;
    assign rx_byte = rx_shift_q;

endmodule

// File: rtl/mf8_io_uart.sv
// mf8 I/O responder: 4-register 8N1 UART, zero-wait bus, combinational read data.
// TX holds one byte (writes while full are dropped); RX has one byte, overrun keeps the old one.
module mf8_io_uart
    import mf8_io_uart_pkg::*;
#(
    parameter logic [5:0]  BASE_ADDR   = 6'h08,
    parameter logic [15:0] DIV_DEFAULT = 16'd103
)
(
    input  logic          Clk,
    input  logic          Reset_n,
    mf8_io_uart_if.slave  io,
    output logic          TXD,
    input  logic          RXD,
    output logic          Irq
);

    logic [5:0]  offs;
    logic        hit;
    logic [1:0]  reg_sel;
    logic        wr_data, wr_stat, wr_divl, wr_divh, rx_rd;

    logic [15:0] div_q;
    logic [7:0]  tx_hold_q;
    logic        tx_full_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q, ovr_q, ferr_q, txie_q;

    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_load, tx_bit_end, tx_busy;

    logic [7:0]  rx_byte;
    logic        rx_stb, rx_ferr;

    // Wrapping subtraction: addresses below BASE_ADDR land far out of range.
    assign offs    = io.IO_Addr - BASE_ADDR;
    assign hit     = (offs[5:2] == 4'd0);
    assign reg_sel = offs[1:0];

    assign wr_data = io.IO_Wr & hit & (reg_sel == REG_DATA);
    assign wr_stat = io.IO_Wr & hit & (reg_sel == REG_STAT);
    assign wr_divl = io.IO_Wr & hit & (reg_sel == REG_DIVL);
    assign wr_divh = io.IO_Wr & hit & (reg_sel == REG_DIVH);
    assign rx_rd   = io.IO_Rd & ~io.IO_Wr & hit & (reg_sel == REG_DATA);

    mf8_uart_rx u_rx (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .RXD     (RXD),
        .div     (div_q),
        .rx_byte (rx_byte),
        .rx_stb  (rx_stb),
        .rx_ferr (rx_ferr)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_q      <= DIV_DEFAULT;
            tx_hold_q  <= 8'h00;
            tx_full_q  <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            txie_q     <= 1'b0;
        end else begin
            if (wr_divl) div_q[7:0]  <= io.IO_WData;
            if (wr_divh) div_q[15:8] <= io.IO_WData;

            if (tx_load) begin
                tx_full_q <= 1'b0;
            end else if (wr_data && !tx_full_q) begin
                tx_hold_q <= io.IO_WData;
                tx_full_q <= 1'b1;
            end

            if (wr_stat) txie_q <= io.IO_WData[STAT_TXIE];

            // Hardware set beats software clear so an error event is never lost.
            if (rx_stb && rx_valid_q && !rx_rd)           ovr_q <= 1'b1;
            else if (wr_stat && io.IO_WData[STAT_OVR])    ovr_q <= 1'b0;

            if (rx_stb && rx_ferr)                        ferr_q <= 1'b1;
            else if (wr_stat && io.IO_WData[STAT_FERR])   ferr_q <= 1'b0;

            if (rx_stb && (!rx_valid_q || rx_rd)) begin
                rx_data_q  <= rx_byte;
                rx_valid_q <= 1'b1;
            end else if (rx_rd) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    assign tx_bit_end = (tx_cnt_q == 16'd0);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q - 16'd1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = 16'd0;
                if (tx_full_q) begin
                    tx_load    = 1'b1;
                    tx_state_d = TX_START;
                    tx_cnt_d   = div_q;
                    tx_shift_d = tx_hold_q;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = div_q;
                    tx_bit_d   = 3'd0;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = div_q;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == LAST_DATA_BIT) tx_state_d = TX_STOP;
                    else                           tx_bit_d   = tx_bit_q + 3'd1;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    // A pending byte chains straight into the next start bit.
                    if (tx_full_q) begin
                        tx_load    = 1'b1;
                        tx_state_d = TX_START;
                        tx_cnt_d   = div_q;
                        tx_shift_d = tx_hold_q;
                    end else begin
                        tx_state_d = TX_IDLE;
                        tx_cnt_d   = 16'd0;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign tx_busy = (tx_state_q != TX_IDLE);

    always_comb begin
        TXD = 1'b1;
        if (tx_state_q == TX_START)     TXD = 1'b0;
        else if (tx_state_q == TX_DATA) TXD = tx_shift_q[0];
    end

    always_comb begin
        io.IO_RData = 8'h00;
        if (hit) begin
            case (reg_sel)
                REG_DATA: io.IO_RData = rx_data_q;
                REG_STAT: io.IO_RData = stat_pack(txie_q, ferr_q, ovr_q, rx_valid_q,
                                                  tx_full_q, tx_busy);
                REG_DIVL: io.IO_RData = div_q[7:0];
                REG_DIVH: io.IO_RData = div_q[15:8];
                default:  io.IO_RData = 8'h00;
            endcase
        end
    end

    assign Irq = rx_valid_q | (~tx_full_q & txie_q) | ovr_q | ferr_q;

endmodule

// File: tb/tb_mf8_io_uart.sv
// Directed bench for mf8_io_uart: register access, TX waveform, RX delivery/overrun/errors, reset.
module tb_mf8_io_uart;

    localparam logic [5:0] BASE = 6'h08;
    localparam logic [5:0] A_DATA = BASE;
    localparam logic [5:0] A_STAT = BASE + 6'd1;
    localparam logic [5:0] A_DIVL = BASE + 6'd2;
    localparam logic [5:0] A_DIVH = BASE + 6'd3;

    logic Clk;
    logic Reset_n;
    logic rxd;
    logic txd;
    logic irq;
    int   n_checks;
    int   n_errors;

    mf8_io_uart_if bus ();

    mf8_io_uart #(.BASE_ADDR(BASE), .DIV_DEFAULT(16'd103)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .io      (bus),
        .TXD     (txd),
        .RXD     (rxd),
        .Irq     (irq)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic io_write(input logic [5:0] addr, input logic [7:0] data);
        @(negedge Clk);
        bus.IO_Addr  = addr;
        bus.IO_WData = data;
        bus.IO_Wr    = 1'b1;
        @(negedge Clk);
        bus.IO_Wr    = 1'b0;
    endtask

    task automatic io_read(input logic [5:0] addr, output logic [7:0] data);
        @(negedge Clk);
        bus.IO_Addr = addr;
        bus.IO_Rd   = 1'b1;
        #1 data = bus.IO_RData;
        @(negedge Clk);
        bus.IO_Rd   = 1'b0;
    endtask

    task automatic peek(input logic [5:0] addr, output logic [7:0] data);
        bus.IO_Addr = addr;
        #1 data = bus.IO_RData;
    endtask

    // Drives start + 8 data bits + stop at DIV=3; returns just after the stop bit starts.
    task automatic rx_frame(input logic [7:0] b, input logic stop);
        @(negedge Clk);
        rxd = 1'b0;
        repeat (4) @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (4) @(negedge Clk);
        end
        rxd = stop;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        rx_frame(b, stop);
        repeat (4) @(negedge Clk);
        rxd = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    logic [7:0] rd;
    logic [9:0] f1, f2;
    logic       exp_bit;

    initial begin
        n_checks = 0;
        n_errors = 0;
        Reset_n = 1'b0;
        rxd = 1'b1;
        bus.IO_Rd = 1'b0;
        bus.IO_Wr = 1'b0;
        bus.IO_Addr = 6'h00;
        bus.IO_WData = 8'h00;
        repeat (3) @(negedge Clk);

        // Reset state
        chk("rst_txd", {15'd0, txd}, 16'd1);
        chk("rst_irq", {15'd0, irq}, 16'd0);
        peek(A_STAT, rd); chk("rst_stat", {8'd0, rd}, 16'h0000);
        peek(A_DIVL, rd); chk("rst_divl", {8'd0, rd}, 16'd103);
        peek(A_DIVH, rd); chk("rst_divh", {8'd0, rd}, 16'h0000);
        peek(A_DATA, rd); chk("rst_data", {8'd0, rd}, 16'h0000);
        @(negedge Clk);
        Reset_n = 1'b1;

        // TX: A5 then back-to-back 5A, FF dropped while holding reg full
        io_write(A_DIVL, 8'd3);
        io_write(A_DIVH, 8'd0);
        peek(A_DIVL, rd); chk("divl_rb", {8'd0, rd}, 16'h0003);
        f1 = {1'b1, 8'hA5, 1'b0};
        f2 = {1'b1, 8'h5A, 1'b0};
        io_write(A_DATA, 8'hA5);
        for (int i = 0; i < 80; i++) begin
            @(negedge Clk);
            exp_bit = (i < 40) ? f1[i / 4] : f2[(i - 40) / 4];
            chk($sformatf("txd_%0d", i), {15'd0, txd}, {15'd0, exp_bit});
            if (i == 1) begin
                bus.IO_Addr = A_DATA; bus.IO_WData = 8'h5A; bus.IO_Wr = 1'b1;
            end else if (i == 2) begin
                bus.IO_WData = 8'hFF;
            end else if (i == 3) begin
                bus.IO_Wr = 1'b0; bus.IO_Addr = A_STAT;
            end else if (i == 5) begin
                #1 chk("stat_busy_full", {8'd0, bus.IO_RData}, 16'h0003);
            end else if (i == 41) begin
                #1 chk("stat_busy_chain", {8'd0, bus.IO_RData}, 16'h0001);
            end
        end
        @(negedge Clk);
        chk("tx_idle_txd", {15'd0, txd}, 16'd1);
        peek(A_STAT, rd); chk("tx_idle_stat", {8'd0, rd}, 16'h0000);
        chk("tx_idle_irq", {15'd0, irq}, 16'd0);

        // TXIE with empty holding register raises Irq
        io_write(A_STAT, 8'h80);
        peek(A_STAT, rd); chk("txie_stat", {8'd0, rd}, 16'h0080);
        chk("txie_irq", {15'd0, irq}, 16'd1);
        io_write(A_STAT, 8'h00);
        chk("txie_off_irq", {15'd0, irq}, 16'd0);

        // RX single byte
        rx_send(8'h3C, 1'b1);
        peek(A_STAT, rd); chk("rx_valid", {8'd0, rd}, 16'h0004);
        chk("rx_irq", {15'd0, irq}, 16'd1);
        io_read(A_DATA, rd); chk("rx_data", {8'd0, rd}, 16'h003C);
        peek(A_STAT, rd); chk("rx_cleared", {8'd0, rd}, 16'h0000);
        chk("rx_irq_clr", {15'd0, irq}, 16'd0);

        // Overrun keeps first byte; w1c clears OVR
        rx_send(8'h11, 1'b1);
        rx_send(8'h22, 1'b1);
        peek(A_STAT, rd); chk("ovr_stat", {8'd0, rd}, 16'h000C);
        peek(A_DATA, rd); chk("ovr_data", {8'd0, rd}, 16'h0011);
        io_write(A_STAT, 8'h08);
        peek(A_STAT, rd); chk("ovr_w1c", {8'd0, rd}, 16'h0004);
        io_read(A_DATA, rd); chk("ovr_read", {8'd0, rd}, 16'h0011);

        // Framing error still delivers the byte; short glitch yields nothing
        rx_send(8'h81, 1'b0);
        peek(A_STAT, rd); chk("ferr_stat", {8'd0, rd}, 16'h0014);
        peek(A_DATA, rd); chk("ferr_data", {8'd0, rd}, 16'h0081);
        io_write(A_STAT, 8'h10);
        io_read(A_DATA, rd);
        peek(A_STAT, rd); chk("ferr_clr", {8'd0, rd}, 16'h0000);
        @(negedge Clk);
        rxd = 1'b0;
        repeat (2) @(negedge Clk);
        rxd = 1'b1;
        repeat (60) @(negedge Clk);
        peek(A_STAT, rd); chk("glitch_stat", {8'd0, rd}, 16'h0000);

        // Read DATA in the exact stop-sample cycle of the next frame
        rx_send(8'h47, 1'b1);
        rx_frame(8'h99, 1'b1);
        repeat (4) @(negedge Clk);
        bus.IO_Addr = A_DATA;
        bus.IO_Rd = 1'b1;
        #1 chk("race_old", {8'd0, bus.IO_RData}, 16'h0047);
        @(negedge Clk);
        bus.IO_Rd = 1'b0;
        peek(A_STAT, rd); chk("race_stat", {8'd0, rd}, 16'h0004);
        peek(A_DATA, rd); chk("race_data", {8'd0, rd}, 16'h0099);
        io_read(A_DATA, rd);

        // Out-of-range addresses
        peek(BASE + 6'd4, rd); chk("oor_hi", {8'd0, rd}, 16'h0000);
        peek(BASE - 6'd1, rd); chk("oor_lo", {8'd0, rd}, 16'h0000);

        // Reset mid-frame forces TXD high without a clock edge
        io_write(A_DATA, 8'h00);
        repeat (3) @(negedge Clk);
        chk("mid_txd_low", {15'd0, txd}, 16'd0);
        #2 Reset_n = 1'b0;
        #1 chk("arst_txd", {15'd0, txd}, 16'd1);
        peek(A_STAT, rd); chk("arst_stat", {8'd0, rd}, 16'h0000);
        peek(A_DIVL, rd); chk("arst_divl", {8'd0, rd}, 16'd103);
        chk("arst_irq", {15'd0, irq}, 16'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
